// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter.
// Sends one command byte to a keyboard using the inhibit / request-to-send
// sequence, then shifts out start, 8 data bits (LSB first), odd parity and
// stop on the device-generated clock, and checks the device acknowledge.
// Both lines are open-drain: the block only ever pulls low or releases.
module ps2_transmitter #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int RTS_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] tx_byte,
  inout  wire        ps2_clk,
  inout  wire        ps2_data,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // One shared counter serves the inhibit, request-to-send and watchdog
  // phases, so it is sized for the longest of the three.
  localparam int MAX_A   = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int MAX_CNT = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST     = CNT_W'(RTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_XFER,
    S_WAIT_IDLE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       edge_cnt, edge_n;
  logic [7:0]       byte_q, byte_n;
  logic             par_q, par_n;
  logic             ack_err, ack_n;
  logic             clk_oe, clk_oe_n;
  logic             data_oe, data_oe_n;
  logic             busy_n, done_n, error_n;

  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic fall;

  // Open-drain pads: pull low when enabled, otherwise leave to the pull-up.
  assign ps2_clk  = clk_oe  ? 1'b0 : 1'bz;
  assign ps2_data = data_oe ? 1'b0 : 1'bz;

  // Two-flop synchronizers for both lines plus the previous synced clock.
  // Idle lines read high, so the flops reset to 1 to avoid a false edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  // While we hold the clock low in INHIBIT/RTS, clk_prev settles at 0, so
  // the first edge seen after release is a genuine device falling edge.
  assign fall = clk_prev & ~clk_s2;

  // Next-state, counter and line-drive decisions for the frame sequencer.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    edge_n    = edge_cnt;
    byte_n    = byte_q;
    par_n     = par_q;
    ack_n     = ack_err;
    clk_oe_n  = clk_oe;
    data_oe_n = data_oe;
    done_n    = 1'b0;
    error_n   = 1'b0;

    case (state)
      S_IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (send) begin
          state_n  = S_INHIBIT;
          byte_n   = tx_byte;
          par_n    = ~^tx_byte;
          cnt_n    = '0;
          edge_n   = '0;
          ack_n    = 1'b0;
          clk_oe_n = 1'b1;
        end
      end

      S_INHIBIT: begin
        if (cnt == INHIBIT_LAST) begin
          state_n   = S_RTS;
          cnt_n     = '0;
          data_oe_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_RTS: begin
        if (cnt == RTS_LAST) begin
          // Watchdog starts from zero on the first cycle with the clock released.
          state_n  = S_XFER;
          cnt_n    = '0;
          clk_oe_n = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_XFER: begin
        if (cnt == TIMEOUT_LAST) begin
          state_n   = S_IDLE;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          error_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
          if (fall) begin
            // edge_cnt holds the count before this edge: 0..7 select data
            // bits, 8 the parity bit, 9 the stop bit, 10 the ack slot.
            edge_n = edge_cnt + 1'b1;
            if (edge_cnt <= 4'd7) begin
              data_oe_n = ~byte_q[edge_cnt[2:0]];
            end else if (edge_cnt == 4'd8) begin
              data_oe_n = ~par_q;
            end else if (edge_cnt == 4'd9) begin
              data_oe_n = 1'b0;
            end else begin
              ack_n     = data_s2;
              data_oe_n = 1'b0;
              state_n   = S_WAIT_IDLE;
            end
          end
        end
      end

      S_WAIT_IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (cnt == TIMEOUT_LAST) begin
          state_n = S_IDLE;
          error_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
          if (clk_s2 && data_s2) begin
            state_n = S_IDLE;
            done_n  = ~ack_err;
            error_n = ack_err;
          end
        end
      end

      default: begin
        state_n   = S_IDLE;
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

  // State register and registered outputs; reset releases both lines at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      edge_cnt <= '0;
      byte_q   <= '0;
      par_q    <= 1'b0;
      ack_err  <= 1'b0;
      clk_oe   <= 1'b0;
      data_oe  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      edge_cnt <= edge_n;
      byte_q   <= byte_n;
      par_q    <= par_n;
      ack_err  <= ack_n;
      clk_oe   <= clk_oe_n;
      data_oe  <= data_oe_n;
      busy     <= busy_n;
      done     <= done_n;
      error    <= error_n;
    end
  end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Testbench for ps2_transmitter: a PS/2 keyboard model on pulled-up lines,
// a per-cycle compare process for the host-side timing and handshake, and
// directed frames with hand-computed expected bit patterns.
module tb_ps2_transmitter;

  localparam int I = 100;   // inhibit cycles
  localparam int R = 16;    // request-to-send cycles
  localparam int T = 5000;  // watchdog cycles
  localparam int H = 40;    // device clock half period (scaled down)

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       send = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  wire        ps2_clk;
  wire        ps2_data;
  logic       busy, done, error;

  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

  ps2_transmitter #(
    .INHIBIT_CYCLES(I),
    .RTS_CYCLES(R),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock(clock),
    .reset(reset),
    .send(send),
    .tx_byte(tx_byte),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected frame as sampled by the device: index 0 = start bit,
  // 1..8 = data LSB first, 9 = odd parity, 10 = stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  // Frame bookkeeping shared between driver and compare process.
  bit mon_en = 1'b0;
  bit active = 1'b0;
  bit exp_ok = 1'b0;
  bit exp_timeout = 1'b0;
  int t_send = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  logic [10:0] sampled;

  // Per-cycle check of host-side timing and handshake against the frame model.
  always @(negedge clock) begin : cmp
    int rel;
    if (mon_en) begin
      rel = cyc - t_send;
      check("done_error_exclusive", int'(done & error), 0);
      if (active) begin
        if (rel >= 1 && rel <= I + R) check("clk_low_inhibit_rts", int'(ps2_clk), 0);
        if (rel >= 1 && rel <= I)     check("data_high_inhibit", int'(ps2_data), 1);
        if (rel > I && rel <= I + R)  check("data_low_rts", int'(ps2_data), 0);
        if (rel == I + R + 1)         check("clk_released", int'(ps2_clk), 1);
        if (done || error) begin
          check("busy_low_at_pulse", int'(busy), 0);
          check("done_kind", int'(done), int'(exp_ok));
          check("error_kind", int'(error), int'(!exp_ok));
          if (exp_timeout) check("timeout_cycle", rel, I + R + 1 + T);
          done_cnt += int'(done);
          err_cnt  += int'(error);
          active = 1'b0;
        end else if (rel >= 1) begin
          check("busy_high", int'(busy), 1);
        end
      end else begin
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);
        check("idle_error", int'(error), 0);
      end
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Keyboard model: waits for inhibit and clock release, then generates
  // nfalls clock pulses, sampling data as it releases the clock. With 11
  // pulses it also answers the ack slot (pulling data low if ack_low).
  task automatic device_frame(input int nfalls, input bit ack_low);
    int k;
    k = 0;
    while (ps2_clk !== 1'b0 && k < 1000) begin @(negedge clock); k++; end
    check("dev_saw_inhibit", int'(ps2_clk), 0);
    k = 0;
    while (ps2_clk !== 1'b1 && k < 1000) begin @(negedge clock); k++; end
    check("dev_saw_release", int'(ps2_clk), 1);
    wait_neg(4);
    sampled[0] = ps2_data;
    for (int b = 1; b <= nfalls && b <= 10; b++) begin
      wait_neg(H);
      dev_clk_low = 1'b1;
      wait_neg(H);
      sampled[b] = ps2_data;
      dev_clk_low = 1'b0;
    end
    if (nfalls >= 11) begin
      wait_neg(H / 2);
      dev_data_low = ack_low;
      wait_neg(H / 2);
      dev_clk_low = 1'b1;
      wait_neg(H);
      dev_clk_low = 1'b0;
      wait_neg(H / 2);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic start_send(input logic [7:0] b);
    @(negedge clock);
    tx_byte = b;
    send = 1'b1;
    t_send = cyc;
    active = 1'b1;
    @(negedge clock);
    send = 1'b0;
    tx_byte = 8'h5A;  // later changes must not affect the frame
  endtask

  // exp_par: expected parity literal, or -1 when not pinned.
  task automatic run_frame(input logic [7:0] b, input bit ack_low, input bit no_dev,
                           input bit mid_send, input int exp_par);
    int k;
    logic [10:0] model;
    done_cnt = 0;
    err_cnt = 0;
    exp_ok = ack_low && !no_dev;
    exp_timeout = no_dev;
    sampled = '0;
    start_send(b);
    fork
      begin
        if (!no_dev) device_frame(11, ack_low);
      end
      begin
        if (mid_send) begin
          wait_neg(400);
          tx_byte = 8'h12;
          send = 1'b1;
          wait_neg(1);
          send = 1'b0;
        end
      end
    join
    k = 0;
    while (active && k < 8000) begin @(negedge clock); k++; end
    check("frame_finished", int'(active), 0);
    check("done_count", done_cnt, exp_ok ? 1 : 0);
    check("error_count", err_cnt, exp_ok ? 0 : 1);
    if (!no_dev) begin
      model = frame_bits(b);
      for (int i = 0; i < 11; i++) check($sformatf("bit%0d", i), int'(sampled[i]), int'(model[i]));
      if (exp_par >= 0) check("parity_literal", int'(sampled[9]), exp_par);
    end
    wait_neg(5);
    check("end_clk_released", int'(ps2_clk), 1);
    check("end_data_released", int'(ps2_data), 1);
  endtask

  initial begin
    // Reset state while reset is held low.
    wait_neg(3);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_clk_z", int'(ps2_clk), 1);
    check("rst_data_z", int'(ps2_data), 1);
    reset = 1'b1;
    wait_neg(3);
    mon_en = 1'b1;

    // 0xED with ack: full frame pinned against the hand-derived pattern.
    run_frame(8'hED, 1'b1, 1'b0, 1'b0, 1);
    check("ed_frame_literal", int'(sampled), int'(11'b11_1110_1101_0));

    // Parity coverage.
    run_frame(8'hF4, 1'b1, 1'b0, 1'b0, 0);
    run_frame(8'h00, 1'b1, 1'b0, 1'b0, 1);
    run_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1);

    // Device leaves the ack bit high.
    run_frame(8'hED, 1'b0, 1'b0, 1'b0, 1);

    // No device at all: watchdog expiry.
    run_frame(8'hED, 1'b0, 1'b1, 1'b0, -1);

    // A second send mid-frame is ignored.
    run_frame(8'hED, 1'b1, 1'b0, 1'b1, 1);
    check("mid_send_literal", int'(sampled), int'(11'b11_1110_1101_0));

    // Reset after the fifth falling edge: host is pulling data low for bit 4.
    done_cnt = 0;
    err_cnt = 0;
    exp_ok = 1'b1;
    exp_timeout = 1'b0;
    start_send(8'hED);
    device_frame(5, 1'b1);
    wait_neg(2);
    check("pre_reset_data_low", int'(ps2_data), 0);
    @(posedge clock);
    #2;
    active = 1'b0;
    reset = 1'b0;
    #1;
    check("reset_clk_z", int'(ps2_clk), 1);
    check("reset_data_z", int'(ps2_data), 1);
    check("reset_busy", int'(busy), 0);
    wait_neg(3);
    reset = 1'b1;
    wait_neg(200);
    check("reset_no_done", done_cnt, 0);
    check("reset_no_error", err_cnt, 0);

    // Clean frame after the reset.
    run_frame(8'hED, 1'b1, 1'b0, 1'b0, 1);
    check("post_reset_literal", int'(sampled), int'(11'b11_1110_1101_0));

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
